// File: rtl/reg_bus_arbiter.sv
`timescale 1ns/1ps
// reg_bus_arbiter: N-client round-robin owner arbiter for the register I/O engine.
// A client holds the bus across any number of commands; an in-flight command
// (ARB_BUSY) is never preempted. Grant rotates from the last released owner.
// Optional idle-owner watchdog: define ARB_TIMEOUT_EN.
// Handshake: req[i] is a level held high for the whole ownership; cli_new_cmd[i]
// is a single-cycle strobe accepted only from the owner in ARB_OWN, forwarded
// combinationally on NewCommand; cmd_done is a single-cycle completion pulse
// honoured only in ARB_BUSY.
module reg_bus_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int OFFSET_W    = 8,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int ID_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                            clk40m,
  input  logic                            RSTN,
  input  logic [NUM_CLIENTS-1:0]          req,
  input  logic [NUM_CLIENTS*OFFSET_W-1:0] cli_offset,
  input  logic [NUM_CLIENTS-1:0]          cli_length,
  input  logic [NUM_CLIENTS-1:0]          cli_wr,
  input  logic [NUM_CLIENTS*DATA_W-1:0]   cli_wdata,
  input  logic [NUM_CLIENTS-1:0]          cli_new_cmd,
  input  logic                            cmd_done,
  output logic [NUM_CLIENTS-1:0]          gnt,
  output logic [ID_W-1:0]                 gnt_id,
  output logic [OFFSET_W-1:0]             offset,
  output logic                            length,
  output logic                            WR,
  output logic [DATA_W-1:0]               writeData,
  output logic                            NewCommand,
  output logic                            bus_idle,
  output logic                            timeout_err,
  output logic [1:0]                      dbg_state
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN  = 2'd1,
    ARB_BUSY = 2'd2
  } arb_state_t;

  arb_state_t             state;
  logic [ID_W-1:0]        last_id;
  logic [NUM_CLIENTS-1:0] eligible;
  logic                   pick_found;
  logic [ID_W-1:0]        pick_id;
  logic [ID_W-1:0]        scan_idx;
  logic                   owner_req;
  logic                   owner_cmd;

  assign dbg_state = state;
  assign owner_req = req[gnt_id];
  assign owner_cmd = cli_new_cmd[gnt_id];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [NUM_CLIENTS-1:0] req_mask;
  logic [CNT_W-1:0]       hold_cnt;

  // A timed-out client stays ineligible until it drops its request.
  assign eligible = req & ~req_mask;
`else
  assign eligible    = req;
  assign timeout_err = 1'b0;
`endif

  // Round-robin search: first eligible client starting at last_id+1, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      scan_idx = ID_W'((int'(last_id) + i) % NUM_CLIENTS);
      if (!pick_found && eligible[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  // Owner field mux; parked values when nobody owns the bus.
  always_comb begin
    offset    = '0;
    length    = 1'b1;
    WR        = 1'b0;
    writeData = '0;
    if (state != ARB_IDLE) begin
      offset    = cli_offset[int'(gnt_id)*OFFSET_W +: OFFSET_W];
      length    = cli_length[gnt_id];
      WR        = cli_wr[gnt_id];
      writeData = cli_wdata[int'(gnt_id)*DATA_W +: DATA_W];
    end
  end

  // Owner strobe passes straight through only while the owner may start a command.
  assign NewCommand = (state == ARB_OWN) && owner_cmd;

  // Ownership FSM with registered gnt/gnt_id/bus_idle.
  always_ff @(posedge clk40m or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ARB_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      bus_idle <= 1'b1;
      last_id  <= ID_W'(NUM_CLIENTS - 1);
`ifdef ARB_TIMEOUT_EN
      req_mask    <= '0;
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
      req_mask    <= req_mask & req;
`endif
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            gnt      <= {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << pick_id;
            gnt_id   <= pick_id;
            bus_idle <= 1'b0;
            state    <= ARB_OWN;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        ARB_OWN: begin
          if (owner_cmd) begin
            state <= ARB_BUSY;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else if (!owner_req) begin
            last_id  <= gnt_id;
            gnt      <= '0;
            bus_idle <= 1'b1;
            state    <= ARB_IDLE;
`ifdef ARB_TIMEOUT_EN
          end else if (hold_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            last_id     <= gnt_id;
            gnt         <= '0;
            bus_idle    <= 1'b1;
            state       <= ARB_IDLE;
            timeout_err <= 1'b1;
            req_mask    <= (req_mask & req) | gnt;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end
        ARB_BUSY: begin
          // Release and new strobes wait for completion; only cmd_done matters.
          if (cmd_done) begin
            state <= ARB_OWN;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        default: begin
          state    <= ARB_IDLE;
          gnt      <= '0;
          bus_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
`timescale 1ns/1ps
// tb_reg_bus_arbiter: per-cycle vector table for grant, pass-through, deferred
// release, reset and rotation, plus a hand-written watchdog sequence.
module tb_reg_bus_arbiter;

  localparam int N  = 4;
  localparam int OW = 8;
  localparam int DW = 16;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic          clk40m = 1'b0;
  logic          RSTN   = 1'b0;
  always #12 clk40m = ~clk40m;

  logic [N-1:0]    req;
  logic [N*OW-1:0] cli_offset;
  logic [N-1:0]    cli_length;
  logic [N-1:0]    cli_wr;
  logic [N*DW-1:0] cli_wdata;
  logic [N-1:0]    cli_new_cmd;
  logic            cmd_done;
  logic [N-1:0]    gnt;
  logic [1:0]      gnt_id;
  logic [OW-1:0]   offset;
  logic            length;
  logic            WR;
  logic [DW-1:0]   writeData;
  logic            NewCommand;
  logic            bus_idle;
  logic            timeout_err;
  logic [1:0]      dbg_state;

  reg_bus_arbiter #(
    .NUM_CLIENTS(N), .OFFSET_W(OW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk40m(clk40m), .RSTN(RSTN), .req(req), .cli_offset(cli_offset),
    .cli_length(cli_length), .cli_wr(cli_wr), .cli_wdata(cli_wdata),
    .cli_new_cmd(cli_new_cmd), .cmd_done(cmd_done), .gnt(gnt), .gnt_id(gnt_id),
    .offset(offset), .length(length), .WR(WR), .writeData(writeData),
    .NewCommand(NewCommand), .bus_idle(bus_idle), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // ---------------- static client fields ----------------
  logic [OW-1:0] c_off [N];
  logic [DW-1:0] c_wd  [N];
  logic          c_wr  [N];
  logic          c_len [N];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus outputs expected for a given owner (or parked values when none).
  task automatic check_bus(input string tag, input logic [3:0] egnt, input logic [1:0] eid);
    logic [OW-1:0] e_off;
    logic [DW-1:0] e_wd;
    logic          e_wr;
    logic          e_len;
    if (egnt == 4'b0000) begin
      e_off = '0; e_wd = '0; e_wr = 1'b0; e_len = 1'b1;
    end else begin
      e_off = c_off[eid]; e_wd = c_wd[eid]; e_wr = c_wr[eid]; e_len = c_len[eid];
    end
    check({tag, " offset"},    32'(offset),    32'(e_off));
    check({tag, " writeData"}, 32'(writeData), 32'(e_wd));
    check({tag, " WR"},        32'(WR),        32'(e_wr));
    check({tag, " length"},    32'(length),    32'(e_len));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] nc;
    logic       done;
    logic [3:0] egnt;
    logic [1:0] eid;
    logic       enc;
  } vec_t;

  vec_t vecs [42];

  function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [3:0] nc,
                              input logic done, input logic [3:0] egnt, input logic [1:0] eid,
                              input logic enc);
    vec_t v;
    v.rst = rst; v.req = rq; v.nc = nc; v.done = done;
    v.egnt = egnt; v.eid = eid; v.enc = enc;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk40m);
    #2;
  endtask

  initial begin
    c_off = '{8'h70, 8'h11, 8'h22, 8'h33};
    c_wd  = '{16'hBEEF, 16'h1111, 16'h2222, 16'h3333};
    c_wr  = '{1'b1, 1'b0, 1'b1, 1'b0};
    c_len = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < N; i++) begin
      cli_offset[i*OW +: OW] = c_off[i];
      cli_wdata[i*DW +: DW]  = c_wd[i];
      cli_wr[i]              = c_wr[i];
      cli_length[i]          = c_len[i];
    end
    req = '0; cli_new_cmd = '0; cmd_done = 1'b0;

    //            rst req      nc       done egnt     id nc
    // reset, first grant, pass-through, second strobe while busy
    vecs[0]  = mk(0, 4'b0101, 4'b0000, 0, 4'b0000, 0, 0);
    vecs[1]  = mk(0, 4'b0101, 4'b0000, 0, 4'b0001, 0, 0);
    vecs[2]  = mk(0, 4'b0101, 4'b0001, 0, 4'b0001, 0, 1);
    vecs[3]  = mk(0, 4'b0101, 4'b0001, 0, 4'b0001, 0, 0);
    vecs[4]  = mk(0, 4'b0101, 4'b0000, 1, 4'b0001, 0, 0);
    vecs[5]  = mk(0, 4'b0100, 4'b0000, 0, 4'b0001, 0, 0);
    vecs[6]  = mk(0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0);
    // owner 2 drops req during a command: released 2 cycles after cmd_done
    vecs[7]  = mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 2, 0);
    vecs[8]  = mk(0, 4'b0100, 4'b0100, 0, 4'b0100, 2, 1);
    vecs[9]  = mk(0, 4'b0000, 4'b0000, 0, 4'b0100, 2, 0);
    vecs[10] = mk(0, 4'b0000, 4'b0000, 0, 4'b0100, 2, 0);
    vecs[11] = mk(0, 4'b0000, 4'b0000, 1, 4'b0100, 2, 0);
    vecs[12] = mk(0, 4'b0000, 4'b0000, 0, 4'b0100, 2, 0);
    vecs[13] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0);
    // client 3 starts a command, reset lands mid-command, stale cmd_done after
    vecs[14] = mk(0, 4'b1000, 4'b0000, 0, 4'b0000, 0, 0);
    vecs[15] = mk(0, 4'b1000, 4'b1000, 0, 4'b1000, 3, 1);
    vecs[16] = mk(1, 4'b1000, 4'b0000, 0, 4'b0000, 0, 0);
    vecs[17] = mk(0, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0);
    // rotation 0,1,2,3,0 with all requesting; non-owner strobe; done+strobe
    vecs[18] = mk(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, 0);
    vecs[19] = mk(0, 4'b1111, 4'b0001, 0, 4'b0001, 0, 1);
    vecs[20] = mk(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 0);
    vecs[21] = mk(0, 4'b1110, 4'b0000, 0, 4'b0001, 0, 0);
    vecs[22] = mk(0, 4'b1110, 4'b0000, 0, 4'b0000, 0, 0);
    vecs[23] = mk(0, 4'b1111, 4'b0000, 0, 4'b0010, 1, 0);
    vecs[24] = mk(0, 4'b1111, 4'b1000, 0, 4'b0010, 1, 0);
    vecs[25] = mk(0, 4'b1111, 4'b0010, 0, 4'b0010, 1, 1);
    vecs[26] = mk(0, 4'b1111, 4'b0010, 1, 4'b0010, 1, 0);
    vecs[27] = mk(0, 4'b1101, 4'b0000, 0, 4'b0010, 1, 0);
    vecs[28] = mk(0, 4'b1101, 4'b0000, 0, 4'b0000, 0, 0);
    vecs[29] = mk(0, 4'b1111, 4'b0000, 0, 4'b0100, 2, 0);
    vecs[30] = mk(0, 4'b1111, 4'b0100, 0, 4'b0100, 2, 1);
    vecs[31] = mk(0, 4'b1111, 4'b0000, 1, 4'b0100, 2, 0);
    vecs[32] = mk(0, 4'b1011, 4'b0000, 0, 4'b0100, 2, 0);
    vecs[33] = mk(0, 4'b1011, 4'b0000, 0, 4'b0000, 0, 0);
    vecs[34] = mk(0, 4'b1111, 4'b0000, 0, 4'b1000, 3, 0);
    vecs[35] = mk(0, 4'b1111, 4'b1000, 0, 4'b1000, 3, 1);
    vecs[36] = mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 3, 0);
    vecs[37] = mk(0, 4'b0111, 4'b0000, 0, 4'b1000, 3, 0);
    vecs[38] = mk(0, 4'b0111, 4'b0000, 0, 4'b0000, 0, 0);
    vecs[39] = mk(0, 4'b0111, 4'b0000, 0, 4'b0001, 0, 0);
    vecs[40] = mk(0, 4'b0110, 4'b0000, 0, 4'b0001, 0, 0);
    vecs[41] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0);

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk40m);
    #3;
    check("rst gnt",         32'(gnt),         32'h0);
    check("rst gnt_id",      32'(gnt_id),      32'h0);
    check("rst bus_idle",    32'(bus_idle),    32'h1);
    check("rst timeout_err", 32'(timeout_err), 32'h0);
    check("rst NewCommand",  32'(NewCommand),  32'h0);
    check("rst state",       32'(dbg_state),   32'h0);
    check_bus("rst", 4'b0000, 2'd0);
    tick();

    // ---------------- table loop ----------------
    for (int i = 0; i < 42; i++) begin
      RSTN        = !vecs[i].rst;
      req         = vecs[i].req;
      cli_new_cmd = vecs[i].nc;
      cmd_done    = vecs[i].done;
      #1;
      check($sformatf("v%0d gnt", i),         32'(gnt),         32'(vecs[i].egnt));
      check($sformatf("v%0d bus_idle", i),    32'(bus_idle),    32'(vecs[i].egnt == 4'b0000));
      check($sformatf("v%0d NewCommand", i),  32'(NewCommand),  32'(vecs[i].enc));
      check($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'h0);
      if (vecs[i].egnt != 4'b0000 || vecs[i].rst)
        check($sformatf("v%0d gnt_id", i), 32'(gnt_id), 32'(vecs[i].eid));
      check_bus($sformatf("v%0d", i), vecs[i].egnt, vecs[i].eid);
      tick();
    end

    // ---------------- idle owner watchdog ----------------
    RSTN = 1'b1; cli_new_cmd = '0; cmd_done = 1'b0;
    req = 4'b0010;
    tick();
    #1;
    check("to grant1", 32'(gnt), 32'h2);
    req = 4'b0110;
    for (int k = 1; k < TO; k++) begin
      @(posedge clk40m);
      #3;
      check($sformatf("to hold%0d gnt", k),  32'(gnt),         32'h2);
      check($sformatf("to hold%0d terr", k), 32'(timeout_err), 32'h0);
    end
`ifdef ARB_TIMEOUT_EN
    @(posedge clk40m);
    #3;
    check("to pulse terr", 32'(timeout_err), 32'h1);
    check("to pulse gnt",  32'(gnt),         32'h0);
    @(posedge clk40m);
    #3;
    check("to after terr", 32'(timeout_err), 32'h0);
    check("to next gnt",   32'(gnt),         32'h4);
    check("to next id",    32'(gnt_id),      32'h2);
    req = 4'b0010;
    repeat (3) @(posedge clk40m);
    #3;
    check("to masked gnt", 32'(gnt), 32'h0);
    req = 4'b0000;
    @(posedge clk40m);
    #3;
    req = 4'b0010;
    @(posedge clk40m);
    #3;
    check("to regrant gnt", 32'(gnt), 32'h2);
`else
    repeat (5) @(posedge clk40m);
    #3;
    check("no-to gnt",  32'(gnt),         32'h2);
    check("no-to terr", 32'(timeout_err), 32'h0);
`endif
    req = 4'b0000;
    repeat (2) @(posedge clk40m);
    #3;
    check("final gnt",      32'(gnt),      32'h0);
    check("final bus_idle", 32'(bus_idle), 32'h1);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
